// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : game_pkg
//  Purpose  : Shared game constants, FSM state type and small helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam int POS_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        HIT  = 2'd2,
        COOL = 2'd3
    } state_t;

    localparam logic [POS_W-1:0] M_W   = 10'd56;
    localparam logic [POS_W-1:0] M_H   = 10'd12;
    localparam logic [POS_W-1:0] R_H   = 10'd30;
    localparam logic [POS_W-1:0] D_W   = 10'd40;
    localparam logic [POS_W-1:0] D_H   = 10'd30;
    localparam logic [POS_W-1:0] H_MAX = 10'd640;
    localparam logic [POS_W-1:0] V_MAX = 10'd480;

    localparam int EV_DRAGON = 1;
    localparam int EV_ROBOT  = 0;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/missile_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : missile_ctrl_if
//  Purpose  : Robot/mixer-side signal bundle of the missile controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface missile_ctrl_if;
    logic       fire_req;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_valid;
    logic [1:0] Event;
    logic [9:0] m_x;
    logic [9:0] m_y;
    logic       m_valid;
    logic       fire_ack;
    logic [7:0] hit_cnt;

    modport master (
        output fire_req, r_x, r_y, r_valid, Event,
        input  m_x, m_y, m_valid, fire_ack, hit_cnt
    );

    modport slave (
        input  fire_req, r_x, r_y, r_valid, Event,
        output m_x, m_y, m_valid, fire_ack, hit_cnt
    );
endinterface
`default_nettype wire

// File: rtl/step_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : step_tick_gen
//  Purpose  : Free-running divider; one-cycle step pulse each DIV cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module step_tick_gen #(
    parameter int DIV = 416667
) (
    input  wire logic clk_25Hz,
    input  wire logic rst,
    output logic      step
);
    localparam int              c_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_W-1:0]  c_LAST = c_W'(DIV - 1);

    logic [c_W-1:0] r_cnt;
    logic           r_step;

    // Pulse is registered so it lines up with the cycle the counter reads 0.
    always_ff @(posedge clk_25Hz or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_step <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
            r_step <= (r_cnt == c_LAST);
        end
    end

    assign step = r_step;
endmodule
`default_nettype wire

// File: rtl/missile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : missile_ctrl
//  Purpose  : Robot missile launch, leftward flight, hit counting, cooldown.
//  Revision : 1.0 - initial release
// ============================================================================
module missile_ctrl
    import game_pkg::*;
#(
    parameter int STEP_DIV   = 416667,
    parameter int SPEED      = 4,
    parameter int COOL_STEPS = 30
) (
    input  wire logic      clk_25Hz,
    input  wire logic      rst,
    missile_ctrl_if.slave  bus
);
    localparam int                c_CW        = $clog2(COOL_STEPS + 1);
    localparam logic [c_CW-1:0]   c_COOL_LAST = c_CW'(COOL_STEPS - 1);
    localparam logic [POS_W-1:0]  c_SPEED     = 10'(SPEED);
    localparam logic [POS_W-1:0]  c_Y_OFF     = (R_H - M_H) >> 1;

    logic             w_step;
    logic             w_fire_edge;
    logic             w_launch;

    state_t           r_state,    w_state_nxt;
    logic [POS_W-1:0] r_m_x,      w_m_x_nxt;
    logic [POS_W-1:0] r_m_y,      w_m_y_nxt;
    logic             r_m_valid,  w_m_valid_nxt;
    logic             r_fire_ack, w_fire_ack_nxt;
    logic [7:0]       r_hit_cnt,  w_hit_cnt_nxt;
    logic [c_CW-1:0]  r_cool,     w_cool_nxt;
    logic             r_fire_prev;

    step_tick_gen #(.DIV(STEP_DIV)) u_tick (
        .clk_25Hz (clk_25Hz),
        .rst      (rst),
        .step     (w_step)
    );

    assign w_fire_edge = bus.fire_req & ~r_fire_prev;
    assign w_launch    = w_fire_edge & bus.r_valid & (bus.r_x >= M_W);

    always_ff @(posedge clk_25Hz or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_m_x       <= '0;
            r_m_y       <= '0;
            r_m_valid   <= 1'b0;
            r_fire_ack  <= 1'b0;
            r_hit_cnt   <= '0;
            r_cool      <= '0;
            r_fire_prev <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_m_x       <= w_m_x_nxt;
            r_m_y       <= w_m_y_nxt;
            r_m_valid   <= w_m_valid_nxt;
            r_fire_ack  <= w_fire_ack_nxt;
            r_hit_cnt   <= w_hit_cnt_nxt;
            r_cool      <= w_cool_nxt;
            r_fire_prev <= bus.fire_req;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_m_x_nxt      = r_m_x;
        w_m_y_nxt      = r_m_y;
        w_m_valid_nxt  = 1'b0;
        w_fire_ack_nxt = 1'b0;
        w_hit_cnt_nxt  = r_hit_cnt;
        w_cool_nxt     = r_cool;

        unique case (r_state)
            IDLE: begin
                if (w_launch) begin
                    w_m_x_nxt      = bus.r_x - M_W;
                    w_m_y_nxt      = bus.r_y + c_Y_OFF;
                    w_m_valid_nxt  = 1'b1;
                    w_fire_ack_nxt = 1'b1;
                    w_state_nxt    = FLY;
                end
            end
            FLY: begin
                w_m_valid_nxt = 1'b1;
                // A dragon hit outranks a coincident motion step.
                if (bus.Event[EV_DRAGON]) begin
                    w_m_valid_nxt = 1'b0;
                    w_hit_cnt_nxt = sat_inc8(r_hit_cnt);
                    w_state_nxt   = HIT;
                end else if (w_step) begin
                    if (r_m_x < c_SPEED) begin
                        w_m_valid_nxt = 1'b0;
                        w_cool_nxt    = '0;
                        w_state_nxt   = COOL;
                    end else begin
                        w_m_x_nxt = r_m_x - c_SPEED;
                    end
                end
            end
            HIT: begin
                // The mixer holds Event for a long time; wait it out once.
                if (!bus.Event[EV_DRAGON]) begin
                    w_cool_nxt  = '0;
                    w_state_nxt = COOL;
                end
            end
            COOL: begin
                if (w_step) begin
                    if (r_cool == c_COOL_LAST) begin
                        w_cool_nxt  = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cool_nxt = r_cool + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.m_x      = r_m_x;
    assign bus.m_y      = r_m_y;
    assign bus.m_valid  = r_m_valid;
    assign bus.fire_ack = r_fire_ack;
    assign bus.hit_cnt  = r_hit_cnt;
endmodule
`default_nettype wire
